// File: rtl/mips_decode_pkg.sv
// Encodings, instruction IDs and hazard helper shared by the MIPS decode stage.
package mips_decode_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_REGIMM = 6'b000001, OP_J = 6'b000010,
      OP_JAL = 6'b000011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
      OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100,
      OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_COP0 = 6'b010000,
      OP_SPECIAL2 = 6'b011100, OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011,
      OP_LBU = 6'b100100, OP_LHU = 6'b100101, OP_SB = 6'b101000, OP_SH = 6'b101001,
      OP_SW = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA = 6'b000011,
      FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111, FN_JR = 6'b001000,
      FN_JALR = 6'b001001, FN_SYSCALL = 6'b001100, FN_BREAK = 6'b001101, FN_MFHI = 6'b010000,
      FN_MTHI = 6'b010001, FN_MFLO = 6'b010010, FN_MTLO = 6'b010011, FN_MULT = 6'b011000,
      FN_MULTU = 6'b011001, FN_DIV = 6'b011010, FN_DIVU = 6'b011011, FN_ADD = 6'b100000,
      FN_ADDU = 6'b100001, FN_SUB = 6'b100010, FN_SUBU = 6'b100011, FN_AND = 6'b100100,
      FN_OR = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111, FN_SLT = 6'b101010,
      FN_SLTU = 6'b101011, FN_TEQ = 6'b110100, FN_ERET = 6'b011000, FN_CLZ = 6'b100000;

   localparam logic [4:0] RT_BGEZ = 5'b00001, RS_MFC0 = 5'b00000, RS_MTC0 = 5'b00100,
      RS_ERET = 5'b10000;

   localparam logic [5:0] ID_ILLEGAL = 6'd0,
      ID_ADD = 6'd1, ID_ADDU = 6'd2, ID_SUB = 6'd3, ID_SUBU = 6'd4, ID_AND = 6'd5,
      ID_OR = 6'd6, ID_XOR = 6'd7, ID_NOR = 6'd8, ID_SLT = 6'd9, ID_SLTU = 6'd10,
      ID_SLL = 6'd11, ID_SRL = 6'd12, ID_SRA = 6'd13, ID_SLLV = 6'd14, ID_SRLV = 6'd15,
      ID_SRAV = 6'd16, ID_JR = 6'd17, ID_ADDI = 6'd18, ID_ADDIU = 6'd19, ID_ANDI = 6'd20,
      ID_ORI = 6'd21, ID_XORI = 6'd22, ID_LUI = 6'd23, ID_LW = 6'd24, ID_SW = 6'd25,
      ID_BEQ = 6'd26, ID_BNE = 6'd27, ID_SLTI = 6'd28, ID_SLTIU = 6'd29, ID_J = 6'd30,
      ID_JAL = 6'd31, ID_DIV = 6'd32, ID_DIVU = 6'd33, ID_MULT = 6'd34, ID_MULTU = 6'd35,
      ID_BGEZ = 6'd36, ID_JALR = 6'd37, ID_LBU = 6'd38, ID_LHU = 6'd39, ID_LB = 6'd40,
      ID_LH = 6'd41, ID_SB = 6'd42, ID_SH = 6'd43, ID_BREAK = 6'd44, ID_SYSCALL = 6'd45,
      ID_ERET = 6'd46, ID_TEQ = 6'd47, ID_MFHI = 6'd48, ID_MFLO = 6'd49, ID_MTHI = 6'd50,
      ID_MTLO = 6'd51, ID_MFC0 = 6'd52, ID_MTC0 = 6'd53, ID_CLZ = 6'd54;

   typedef struct packed {
      logic [5:0]  id;
      logic        illegal;
      logic [31:0] instr;
      logic [31:0] pc;
   } dec_entry_t;

   // Instructions that touch HI/LO or start a new MULT/DIV must wait for the unit.
   function automatic logic is_hilo_dep(input logic [5:0] id);
      return id inside {ID_DIV, ID_DIVU, ID_MULT, ID_MULTU, ID_MFHI, ID_MFLO, ID_MTHI, ID_MTLO};
   endfunction

endpackage

// File: rtl/mips_decode_comb.sv
// Purely combinational instruction word -> {id, illegal}; zero latency, no flow control.
// With EXT_EN=0 the extended IDs (32 and up) are reported as illegal.
module mips_decode_comb
   import mips_decode_pkg::*;
#(
   parameter bit EXT_EN = 1'b1
) (
   input  logic [31:0] instr,
   output logic [5:0]  id,
   output logic        illegal
);

   logic [5:0] op, func, raw_id;
   logic [4:0] rs, rt;

   assign op   = instr[31:26];
   assign rs   = instr[25:21];
   assign rt   = instr[20:16];
   assign func = instr[5:0];

   always_comb begin
      raw_id = ID_ILLEGAL;
      case (op)
         OP_SPECIAL: begin
            case (func)
               FN_ADD: raw_id = ID_ADD;     FN_ADDU: raw_id = ID_ADDU;
               FN_SUB: raw_id = ID_SUB;     FN_SUBU: raw_id = ID_SUBU;
               FN_AND: raw_id = ID_AND;     FN_OR: raw_id = ID_OR;
               FN_XOR: raw_id = ID_XOR;     FN_NOR: raw_id = ID_NOR;
               FN_SLT: raw_id = ID_SLT;     FN_SLTU: raw_id = ID_SLTU;
               FN_SLL: raw_id = ID_SLL;     FN_SRL: raw_id = ID_SRL;
               FN_SRA: raw_id = ID_SRA;     FN_SLLV: raw_id = ID_SLLV;
               FN_SRLV: raw_id = ID_SRLV;   FN_SRAV: raw_id = ID_SRAV;
               FN_JR: raw_id = ID_JR;       FN_DIV: raw_id = ID_DIV;
               FN_DIVU: raw_id = ID_DIVU;   FN_MULT: raw_id = ID_MULT;
               FN_MULTU: raw_id = ID_MULTU; FN_JALR: raw_id = ID_JALR;
               FN_BREAK: raw_id = ID_BREAK; FN_SYSCALL: raw_id = ID_SYSCALL;
               FN_TEQ: raw_id = ID_TEQ;     FN_MFHI: raw_id = ID_MFHI;
               FN_MFLO: raw_id = ID_MFLO;   FN_MTHI: raw_id = ID_MTHI;
               FN_MTLO: raw_id = ID_MTLO;
               default: raw_id = ID_ILLEGAL;
            endcase
         end
         OP_ADDI: raw_id = ID_ADDI;   OP_ADDIU: raw_id = ID_ADDIU;
         OP_ANDI: raw_id = ID_ANDI;   OP_ORI: raw_id = ID_ORI;
         OP_XORI: raw_id = ID_XORI;   OP_LUI: raw_id = ID_LUI;
         OP_LW: raw_id = ID_LW;       OP_SW: raw_id = ID_SW;
         OP_BEQ: raw_id = ID_BEQ;     OP_BNE: raw_id = ID_BNE;
         OP_SLTI: raw_id = ID_SLTI;   OP_SLTIU: raw_id = ID_SLTIU;
         OP_J: raw_id = ID_J;         OP_JAL: raw_id = ID_JAL;
         OP_LBU: raw_id = ID_LBU;     OP_LHU: raw_id = ID_LHU;
         OP_LB: raw_id = ID_LB;       OP_LH: raw_id = ID_LH;
         OP_SB: raw_id = ID_SB;       OP_SH: raw_id = ID_SH;
         OP_REGIMM: raw_id = (rt == RT_BGEZ) ? ID_BGEZ : ID_ILLEGAL;
         OP_COP0: begin
            if (rs == RS_ERET && func == FN_ERET) raw_id = ID_ERET;
            else if (rs == RS_MFC0) raw_id = ID_MFC0;
            else if (rs == RS_MTC0) raw_id = ID_MTC0;
         end
         OP_SPECIAL2: raw_id = (func == FN_CLZ) ? ID_CLZ : ID_ILLEGAL;
         default: raw_id = ID_ILLEGAL;
      endcase
   end

   assign id      = (!EXT_EN && raw_id >= ID_DIV) ? ID_ILLEGAL : raw_id;
   assign illegal = (id == ID_ILLEGAL);

endmodule

// File: rtl/mips_decode_stage.sv
// Registered decode into a DEPTH-entry queue; 1-cycle latency into an empty queue.
// in_ready drops when full, flushing, or a HI/LO dependent op meets a busy MULT/DIV unit.
module mips_decode_stage
   import mips_decode_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter bit EXT_EN  = 1'b1,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_id,
   output logic        out_illegal,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_shamt,
   output logic [15:0] out_imm,
   output logic [25:0] out_target,
   output logic [31:0] out_pc,
   output logic        hilo_busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   logic [5:0]    dec_id;
   logic          dec_illegal;
   dec_entry_t    mem [DEPTH];
   dec_entry_t    head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [5:0]    busy_cnt;
   logic          stall, push, pop;

   mips_decode_comb #(.EXT_EN(EXT_EN)) u_dec (
      .instr  (in_instr),
      .id     (dec_id),
      .illegal(dec_illegal)
   );

   assign stall     = (busy_cnt != 6'd0) && is_hilo_dep(dec_id);
   assign in_ready  = (count < DEPTH_C) && !stall && !flush;
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;
   assign hilo_busy = (busy_cnt != 6'd0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{id: dec_id, illegal: dec_illegal, instr: in_instr, pc: in_pc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // The counter models the arithmetic unit, so flush leaves it running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_cnt <= 6'd0;
      else if (push && (dec_id == ID_MULT || dec_id == ID_MULTU))
         busy_cnt <= 6'(MUL_LAT);
      else if (push && (dec_id == ID_DIV || dec_id == ID_DIVU))
         busy_cnt <= 6'(DIV_LAT);
      else if (busy_cnt != 6'd0)
         busy_cnt <= busy_cnt - 6'd1;
   end

   // Head fields read as zero whenever the queue is empty.
   assign head        = mem[rd_ptr];
   assign out_id      = out_valid ? head.id : 6'd0;
   assign out_illegal = out_valid ? head.illegal : 1'b0;
   assign out_rs      = out_valid ? head.instr[25:21] : 5'd0;
   assign out_rt      = out_valid ? head.instr[20:16] : 5'd0;
   assign out_rd      = out_valid ? head.instr[15:11] : 5'd0;
   assign out_shamt   = out_valid ? head.instr[10:6] : 5'd0;
   assign out_imm     = out_valid ? head.instr[15:0] : 16'd0;
   assign out_target  = out_valid ? head.instr[25:0] : 26'd0;
   assign out_pc      = out_valid ? head.pc : 32'd0;

endmodule

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
Registered, parametrised instruction-decode stage for the 54-instruction MIPS core. It accepts 32-bit instruction words over a valid/ready handshake and emits an encoded instruction ID plus extracted fields and an illegal flag through a small output queue. It also tracks MULT/DIV occupancy of HI/LO and stalls dependent instructions. It sits between the fetch buffer and the control/execute logic, replacing per-instruction flag decoding.

Parameters:
DEPTH, 2, output queue entries (1..8)
EXT_EN, 1, 1 = full 54-instruction set; 0 = IDs 32..54 decode as illegal
MUL_LAT, 4, HI/LO busy cycles after a MULT/MULTU is accepted (1..63)
DIV_LAT, 33, HI/LO busy cycles after a DIV/DIVU is accepted (1..63)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  drop all queued entries
in_valid  in  1  instruction word valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  32  PC of instruction
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head
out_id  out  6  encoded instruction ID; 0 = illegal
out_illegal  out  1  unrecognised, or extended while EXT_EN=0
out_rs/out_rt/out_rd/out_shamt  out  5 each  instr[25:21]/[20:16]/[15:11]/[10:6]
out_imm  out  16  instr[15:0]
out_target  out  26  instr[25:0]
out_pc  out  32  PC of head entry
hilo_busy  out  1  busy counter non-zero

Behaviour:
- Reset (async, any time, including mid-stall): queue empty, out_valid=0, all out_* fields 0, busy counter 0, hilo_busy=0. in_ready reflects the post-reset state combinationally (1).
- ID order, from 1: ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR (1-17); ADDI ADDIU ANDI ORI XORI LUI LW SW BEQ BNE SLTI SLTIU (18-29); J JAL (30-31); DIV DIVU MULT MULTU BGEZ JALR LBU LHU LB LH SB SH BREAK SYSCALL ERET TEQ MFHI MFLO MTHI MTLO MFC0 MTC0 CLZ (32-54).
- Strict decode:
  - op=000000 with an unlisted func -> illegal.
  - BGEZ requires op=000001 and rt=00001.
  - ERET requires op=010000, rs=10000, func=011000.
  - MFC0 requires op=010000, rs=00000. MTC0 requires op=010000, rs=00100.
  - CLZ requires op=011100, func=100000.
  - Anything else -> out_id=0, out_illegal=1.
  - Illegal entries are still queued; the stage never drops them.
- Decode is combinational on in_instr and registered into the queue.
- Latency: an accepted word appears on out_* on the next cycle when the queue was empty.
- Queue is a FIFO of DEPTH entries.
  - Push on in_valid && in_ready. Pop on out_valid && out_ready. Simultaneous push and pop keep the count unchanged.
  - in_ready = (count < DEPTH) && !stall. A full queue blocks a push even if a pop occurs the same cycle.
  - out_* hold stable while out_valid && !out_ready.
- Stall: in_ready=0 when the busy counter is non-zero and the presented instruction is MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV or DIVU.
- Busy counter (6 bits):
  - On acceptance of MULT/MULTU it loads MUL_LAT; on DIV/DIVU it loads DIV_LAT.
  - Otherwise it decrements by 1 while non-zero and saturates at 0.
  - Loads can only occur when the counter is 0, because of the stall rule.
- Flush:
  - Empties the queue; out_valid=0 on the next cycle.
  - The input handshake is ignored that cycle (in_ready=0).
  - The busy counter is not cleared; the arithmetic unit keeps running.

Decomposition:
- Package mips_decode_pkg holds:
  - op/func/rs/rt encoding constants;
  - ID localparams ID_ILLEGAL=0 .. ID_CLZ=54;
  - function is_hilo_dep(id).
- Sub-module mips_decode_comb: pure combinational instr -> {id, illegal}, with EXT_EN.
- The queue and busy counter stay in the top level.

Test Plan:
- ADDU $3,$1,$2 = 0x00221821 with out_ready=1 -> next cycle out_id=2, out_rs=1, out_rt=2, out_rd=3, out_illegal=0.
- MULT 0x00220018 accepted, then MFLO 0x00002012 presented -> in_ready=0 for exactly 4 cycles, hilo_busy=1 over the same span; MFLO then accepted and decodes to out_id=49.
- DIV 0x0022001A, then DIV again -> second DIV stalled 33 cycles and decodes to out_id=32. Assert rst mid-stall -> in_ready=1 and hilo_busy=0 immediately.
- BGEZ 0x04210004 -> out_id=36. BLTZ 0x04200004 -> out_id=0, out_illegal=1. ERET 0x42000018 -> out_id=46. With EXT_EN=0, ERET -> out_illegal=1.
- DEPTH=2, out_ready=0, push 3 words -> in_ready=0 after 2. Then pop and push in the same cycle -> push refused while full, count goes 2->1 and the third word is accepted the next cycle; FIFO order is preserved.
- Fill the queue, assert flush one cycle -> out_valid=0 the next cycle. A MULT accepted before the flush still holds hilo_busy=1 until its count expires.
